tdc_result_framer: RTL and testbench
====================================

TDC_RESULT_FRAMER -- requirements
Module: tdc_result_framer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of queued measurements; SHALL be a power of two, 2..16.
REQ-002 Port: clk  input  1  single 200 MHz clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: meas_in  input  40  TDC measurement word: [39:34] zero, [33:5] coarse ticks, [4:0] fine ticks.
REQ-005 Port: meas_valid_in  input  1  one-cycle strobe qualifying meas_in.
REQ-006 Port: tx_data  output  8  byte offered to the downstream UART transmitter.
REQ-007 Port: tx_valid  output  1  tx_data is valid.
REQ-008 Port: tx_ready  input  1  downstream accepts tx_data this cycle.
REQ-009 Port: fifo_count  output  clog2(FIFO_DEPTH)+1  number of queued entries, excluding any frame in flight.
REQ-010 Port: drop_count  output  8  saturating count of measurements lost to a full queue.
REQ-011 Port: busy  output  1  high while a frame is being transmitted.

Function
REQ-012 The block SHALL hold measurements in a FIFO_DEPTH-entry queue, written in arrival order and read first-in first-out.
REQ-013 A push SHALL occur on every clock edge where meas_valid_in=1 and either fifo_count<FIFO_DEPTH or a pop occurs on the same edge.
REQ-014 If meas_valid_in=1 and the queue is full with no simultaneous pop, the measurement SHALL be discarded and drop_count SHALL increment; it SHALL saturate at 255.
REQ-015 meas_in bits [39:34] SHALL be ignored on input; they SHALL be transmitted as stored, not forced to zero.
REQ-016 The framer FSM SHALL have two states: IDLE and SEND.
REQ-017 In IDLE with fifo_count>0, the block SHALL pop the head entry into a frame register, clear the byte index to 0 and enter SEND on that edge.
REQ-018 Frame format, 7 bytes in order:
- 0xA5
- meas[39:32], meas[31:24], meas[23:16], meas[15:8], meas[7:0]
- checksum = XOR of the five measurement bytes
REQ-019 In SEND, tx_valid SHALL be 1 and tx_data SHALL equal the frame byte selected by the byte index.
REQ-020 The byte index SHALL advance only on edges where tx_valid=1 and tx_ready=1.
REQ-021 tx_data SHALL remain stable while tx_valid=1 and tx_ready=0.
REQ-022 On acceptance of byte 6, the FSM SHALL return to IDLE; tx_valid SHALL be 0 for at least one cycle between frames.
REQ-023 In IDLE, tx_valid SHALL be 0 and tx_data SHALL be 0x00.
REQ-024 Latency: a measurement strobed at edge k into an empty, idle block SHALL produce tx_valid=1 with tx_data=0xA5 after edge k+1.
REQ-025 busy SHALL equal (state==SEND).
REQ-026 tx_ready while tx_valid=0 SHALL have no effect.

Reset
REQ-027 While rst=1, asynchronously:
- state SHALL be IDLE and the queue empty
- tx_valid=0, tx_data=0x00, fifo_count=0, drop_count=0, busy=0
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further bytes; queued entries SHALL be lost.
REQ-029 A meas_valid_in strobe on the first edge after rst deasserts SHALL be accepted normally.

Verification
REQ-030 Single frame: meas_in=40'h12_3456_789A strobed, tx_ready=1 -> tx_data sequence A5 12 34 56 78 9A 92 on 7 consecutive cycles, then tx_valid=0.
REQ-031 Backpressure: same stimulus, tx_ready=0 for 3 cycles while byte index=2 -> tx_data held at 0x34 for those cycles; full sequence unchanged.
REQ-032 Overflow: tx_ready=0, 6 strobes spaced 2 cycles apart (FIFO_DEPTH=4) -> busy=1, fifo_count=4, drop_count=1; after releasing tx_ready, frames for strobes 1-5 in order.
REQ-033 Simultaneous push/pop: queue full, same edge as the pop from IDLE, strobe meas_valid_in -> entry accepted, fifo_count stays 4, drop_count unchanged.
REQ-034 Saturation: tx_ready=0, queue full, 300 further strobes -> drop_count=255.
REQ-035 Reset mid-frame: rst pulsed after byte 3 accepted -> tx_valid=0 immediately, fifo_count=0, drop_count=0; next strobe yields a complete frame starting with 0xA5.

Source files
------------

// File: rtl/tdc_result_framer_if.sv
// ---------------------------------------------------------------------------
// tdc_result_framer_if
//   Bundles the measurement input strobe and the byte-stream handshake
//   toward the downstream UART transmitter.
//
//   meas_in[39:0]  : TDC word ([33:5] coarse ticks, [4:0] fine ticks)
//   meas_valid_in  : one-cycle strobe qualifying meas_in
//   tx_data[7:0]   : byte offered downstream
//   tx_valid       : tx_data is valid
//   tx_ready       : downstream accepts tx_data this cycle
//
//   master : the environment (measurement source + byte sink)
//   slave  : the framer
// ---------------------------------------------------------------------------
interface tdc_result_framer_if;
    logic [39:0] meas_in;
    logic        meas_valid_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output meas_in,
        output meas_valid_in,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  meas_in,
        input  meas_valid_in,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/tdc_result_framer.sv
// ---------------------------------------------------------------------------
// tdc_result_framer
//   Queues TDC measurement words in a small FIFO and serialises each one as
//   a 7-byte frame for a UART transmitter:
//     0xA5, meas[39:32], meas[31:24], meas[23:16], meas[15:8], meas[7:0],
//     XOR of the five measurement bytes.
//   Measurements arriving while the queue is full (and no pop happens on
//   that edge) are discarded and counted in a saturating 8-bit counter.
//
// Ports
//   clk        : single rising-edge clock (200 MHz)
//   rst        : asynchronous, active-high reset
//   bus        : tdc_result_framer_if.slave (measurement in, byte stream out)
//   fifo_count : entries waiting in the queue (frame in flight not included)
//   drop_count : measurements lost to a full queue, saturating at 255
//   busy       : high while a frame is being transmitted
//
// FIFO_DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module tdc_result_framer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    tdc_result_framer_if.slave            bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_count,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    SYNC     = 8'hA5;
    localparam logic [2:0]    LAST_IDX = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Frame byte selected by the byte index.
    function automatic logic [7:0] frame_byte(input logic [39:0] f,
                                              input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC;
            3'd1:    b = f[39:32];
            3'd2:    b = f[31:24];
            3'd3:    b = f[23:16];
            3'd4:    b = f[15:8];
            3'd5:    b = f[7:0];
            3'd6:    b = f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Queue storage
    logic [39:0] mem_q [FIFO_DEPTH];

    // State
    state_t        state_q,    state_d;
    logic [39:0]   frame_q,    frame_d;
    logic [2:0]    idx_q,      idx_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic [7:0]    drop_q,     drop_d;
    logic [7:0]    tx_data_q,  tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          busy_q,     busy_d;

    logic push;
    logic pop;
    logic drop;

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch leaves a signal
        // unassigned and no latch can be inferred.
        state_d  = state_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;

        // A pop frees a slot on the same edge, so a full queue can still
        // accept a strobe when the idle framer is taking its head entry.
        pop  = (state_q == IDLE) && (count_q != '0);
        push = bus.meas_valid_in && ((count_q != DEPTH_C) || pop);
        drop = bus.meas_valid_in && !push;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    frame_d = mem_q[rd_ptr_q];
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_valid_q && bus.tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 3'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

        // Outputs are computed from next-state values so they come straight
        // from flops while still showing 0xA5 on the cycle after the pop.
        tx_valid_d = (state_d == SEND);
        busy_d     = (state_d == SEND);
        tx_data_d  = tx_valid_d ? frame_byte(frame_d, idx_d) : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            idx_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    // NOTE: queue storage has no reset; which entries are live is tracked
    // by the pointers and count, so stale contents are never observed.
    // On a full-queue push+pop the write lands in the slot being read; the
    // frame register still captures the old head because reads see
    // pre-edge contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.meas_in;
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign fifo_count   = count_q;
    assign drop_count   = drop_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_tdc_result_framer.sv
module tb_tdc_result_framer;

    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [39:0] meas;
        logic [7:0]  csum;   // hand-computed XOR of the five data bytes
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fifo_count;
    logic [7:0] drop_count;
    logic       busy;

    tdc_result_framer_if bus();

    tdc_result_framer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_count (fifo_count),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         bytes_acc = 0;
    logic [7:0] exp_q[$];
    vec_t       vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input vec_t v);
        exp_q.push_back(8'hA5);
        exp_q.push_back(v.meas[39:32]);
        exp_q.push_back(v.meas[31:24]);
        exp_q.push_back(v.meas[23:16]);
        exp_q.push_back(v.meas[15:8]);
        exp_q.push_back(v.meas[7:0]);
        exp_q.push_back(v.csum);
    endtask

    // One-cycle strobe, captured on the second posedge of this task.
    task automatic strobe(input vec_t v, input bit accept);
        @(posedge clk); #1;
        bus.meas_in       = v.meas;
        bus.meas_valid_in = 1'b1;
        if (accept) push_frame(v);
        @(posedge clk); #1;
        bus.meas_valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check({name, "_drained"}, done, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Byte monitor / scoreboard: a byte offered with tx_ready high at the
    // falling edge is accepted on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.tx_valid) check("idle_data_zero", bus.tx_data, 0);
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_extra_byte: got %02h, no byte expected", bus.tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("sb_byte", bus.tx_data, e);
                end
                bytes_acc++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [7];
        bit         seen_idle;
        int         target;
        bit         hit;

        vecs[0] = '{meas: 40'h12_3456_789A, csum: 8'h92};
        vecs[1] = '{meas: 40'h00_0000_0000, csum: 8'h00};
        vecs[2] = '{meas: 40'hFF_FFFF_FFFF, csum: 8'hFF};
        vecs[3] = '{meas: 40'h01_0204_0810, csum: 8'h1F};
        vecs[4] = '{meas: 40'hA5_5AA5_5A00, csum: 8'h00};
        vecs[5] = '{meas: 40'h80_4020_1008, csum: 8'hF8};
        seq = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h92};

        rst               = 1'b1;
        bus.meas_in       = '0;
        bus.meas_valid_in = 1'b0;
        bus.tx_ready      = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx_valid",   bus.tx_valid, 0);
        check("rst_tx_data",    bus.tx_data,  0);
        check("rst_fifo_count", fifo_count,   0);
        check("rst_drop_count", drop_count,   0);
        check("rst_busy",       busy,         0);
        rst = 1'b0;

        // Single frame, latency and consecutive bytes
        bus.tx_ready = 1'b1;
        strobe(vecs[0], 1'b1);
        @(negedge clk);
        check("lat_queued",   fifo_count,   1);
        check("lat_no_valid", bus.tx_valid, 0);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            check("single_valid", bus.tx_valid, 1);
            check("single_data",  bus.tx_data,  seq[j]);
            if (j == 0) begin
                check("single_busy",  busy,       1);
                check("single_count", fifo_count, 0);
            end
        end
        @(negedge clk);
        check("single_end_valid", bus.tx_valid, 0);
        drain("single");

        // Backpressure while byte index = 2
        strobe(vecs[0], 1'b1);
        repeat (3) @(posedge clk);
        #1 bus.tx_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("bp_hold_valid", bus.tx_valid, 1);
            check("bp_hold_data",  bus.tx_data,  8'h34);
            @(posedge clk);
        end
        #1 bus.tx_ready = 1'b1;
        drain("backpressure");

        // Table: back-to-back strobes, frames in order
        for (int i = 0; i < 6; i++) strobe(vecs[i], 1'b1);
        drain("table");
        check("table_no_drop", drop_count, 0);

        // Overflow: stalled sink, 6 strobes, the 6th is lost
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) strobe(vecs[i], i < 5);
        @(negedge clk);
        check("ovf_busy",  busy,       1);
        check("ovf_count", fifo_count, 4);
        check("ovf_drop",  drop_count, 1);

        // Release; wait for the idle gap with a full queue, then strobe on
        // the same edge as the pop.
        @(posedge clk); #1 bus.tx_ready = 1'b1;
        seen_idle = 1'b0;
        for (int i = 0; i < 40 && !seen_idle; i++) begin
            @(negedge clk);
            if (!busy) seen_idle = 1'b1;
        end
        check("pp_reached_idle", seen_idle, 1);
        check("pp_full_before",  fifo_count, 4);
        bus.meas_in       = vecs[1].meas;
        bus.meas_valid_in = 1'b1;
        push_frame(vecs[1]);
        @(posedge clk); #1 bus.meas_valid_in = 1'b0;
        @(negedge clk);
        check("pp_count", fifo_count, 4);
        check("pp_drop",  drop_count, 1);
        check("pp_busy",  busy,       1);
        drain("overflow");
        check("ovf_drop_final", drop_count, 1);

        // Saturation of drop_count
        do_reset();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 305; i++) begin
            strobe(vecs[i % 6], i < 5);
            if (i == 258) begin
                @(negedge clk);
                check("sat_drop_254", drop_count, 254);
            end
        end
        @(negedge clk);
        check("sat_drop_255", drop_count, 255);
        check("sat_count",    fifo_count, 4);

        // Reset mid-frame after byte 3 accepted
        @(posedge clk); #1 bus.tx_ready = 1'b1;
        target = bytes_acc + 4;
        hit    = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            if (bytes_acc >= target) hit = 1'b1;
        end
        check("mid_byte3_seen", hit, 1);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_valid", bus.tx_valid, 0);
        check("mid_rst_data",  bus.tx_data,  0);
        check("mid_rst_count", fifo_count,   0);
        check("mid_rst_drop",  drop_count,   0);
        check("mid_rst_busy",  busy,         0);
        repeat (2) @(negedge clk);
        check("mid_rst_quiet", bus.tx_valid, 0);

        // Strobe on the first edge after reset release
        @(negedge clk);
        rst               = 1'b0;
        bus.meas_in       = vecs[3].meas;
        bus.meas_valid_in = 1'b1;
        push_frame(vecs[3]);
        @(posedge clk); #1 bus.meas_valid_in = 1'b0;
        @(negedge clk);
        check("post_rst_accept", fifo_count, 1);
        drain("post_reset");
        check("final_drop", drop_count, 0);
        check("sb_empty",   exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
